// File: rtl/counter_step_monitor.sv
// counter_step_monitor: checks that each of CHANNELS counters advances by STEP (mod 2^WIDTH)
// between valid samples, and reports mismatches through a pulse, sticky flags, a saturating
// count and a first-failure capture.
// Ports:
//   clk, rst (sync, active-high), clear (sync clear of sticky/count/capture)
//   valid[CHANNELS]            per-channel sample strobe
//   cnt_in[CHANNELS*WIDTH]     channel i at [i*WIDTH +: WIDTH]
//   err_pulse[CHANNELS]        registered one-cycle mismatch pulse
//   err_sticky[CHANNELS]       mismatch seen since rst/clear
//   err_count[ERR_CNT_W]       saturating total mismatch count
//   ff_valid, ff_chan, ff_exp, ff_got   first-failure capture
// Optional: define COUNTER_STEP_MONITOR_FATAL_EN to stop simulation on the first mismatch.
module counter_step_monitor #(
   parameter int WIDTH     = 4,
   parameter int CHANNELS  = 4,
   parameter int STEP      = 1,
   parameter int ERR_CNT_W = 8,
   parameter bit STRICT    = 1'b1,
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic [CHANNELS-1:0]       valid,
   input  logic [CHANNELS*WIDTH-1:0] cnt_in,
   output logic [CHANNELS-1:0]       err_pulse,
   output logic [CHANNELS-1:0]       err_sticky,
   output logic [ERR_CNT_W-1:0]      err_count,
   output logic                      ff_valid,
   output logic [CW-1:0]             ff_chan,
   output logic [WIDTH-1:0]          ff_exp,
   output logic [WIDTH-1:0]          ff_got
);
   localparam int NW = $clog2(CHANNELS + 1);
   localparam int SW = ERR_CNT_W + NW;
   typedef enum logic {IDLE, ARMED} state_t;
   state_t state [CHANNELS];
   state_t state_nx [CHANNELS];
   logic [WIDTH-1:0] past [CHANNELS];
   logic [WIDTH-1:0] got [CHANNELS];
   logic [WIDTH-1:0] exp_v [CHANNELS];
   logic [CHANNELS-1:0] mism;
   logic [NW-1:0] n_mism;
   logic [CW-1:0] first;
   logic [SW-1:0] sum;
   logic [ERR_CNT_W-1:0] count_nx;
   // Descending loop so the lowest failing index is the last to overwrite first.
   // A zero sample is never checked, which lets a counter wrap without a false error.
   always_comb begin
      mism = '0;
      n_mism = '0;
      first = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         got[i] = cnt_in[i*WIDTH +: WIDTH];
         exp_v[i] = past[i] + WIDTH'(STEP);
         state_nx[i] = valid[i] ? ARMED : (STRICT ? IDLE : state[i]);
         mism[i] = valid[i] && state[i] == ARMED && got[i] != '0 && got[i] != exp_v[i];
         n_mism = n_mism + NW'(mism[i]);
         first = mism[i] ? CW'(i) : first;
      end
      sum = SW'(err_count) + SW'(n_mism);
      count_nx = sum > SW'({ERR_CNT_W{1'b1}}) ? '1 : sum[ERR_CNT_W-1:0];
   end
   always_ff @(posedge clk)
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            state[i] <= IDLE;
            past[i] <= '0;
         end else begin
            state[i] <= state_nx[i];
            if (valid[i]) past[i] <= got[i];
         end
      end
   always_ff @(posedge clk)
      if (rst) begin
         err_pulse <= '0;
         err_sticky <= '0;
         err_count <= '0;
         ff_valid <= 1'b0;
         ff_chan <= '0;
         ff_exp <= '0;
         ff_got <= '0;
      end else begin
         err_pulse <= mism;
         if (clear) begin
            err_sticky <= '0;
            err_count <= '0;
            ff_valid <= 1'b0;
            ff_chan <= '0;
            ff_exp <= '0;
            ff_got <= '0;
         end else begin
            err_sticky <= err_sticky | mism;
            err_count <= count_nx;
            if (!ff_valid && |mism) begin
               ff_valid <= 1'b1;
               ff_chan <= first;
               ff_exp <= exp_v[first];
               ff_got <= got[first];
            end
         end
      end
`ifdef COUNTER_STEP_MONITOR_FATAL_EN
   // An empty capture means no mismatch since rst/clear, so this fires only once.
   always_ff @(posedge clk)
      if (!rst && !ff_valid && |mism)
         $fatal(1, "counter_step_monitor: channel %0d expected %0d got %0d",
                first, exp_v[first], got[first]);
`else
`endif
endmodule

// File: tb/tb_counter_step_monitor.sv
// tb_counter_step_monitor: directed vectors with hand-computed expectations, checked by a scoreboard monitor.
module tb_counter_step_monitor;
   logic clk, rst, clear;
   logic [3:0] valid;
   logic [15:0] cnt_in;
   logic [3:0] err_pulse, err_sticky;
   logic [1:0] err_count;
   logic ff_valid;
   logic [1:0] ff_chan;
   logic [3:0] ff_exp, ff_got;
   typedef struct packed {
      logic [3:0] p;
      logic [3:0] s;
      logic [1:0] n;
      logic fv;
      logic [1:0] ch;
      logic [3:0] fe;
      logic [3:0] fg;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int nv = 0;
   counter_step_monitor #(.WIDTH(4), .CHANNELS(4), .STEP(1), .ERR_CNT_W(2), .STRICT(1'b1)) dut (
      .clk(clk), .rst(rst), .clear(clear), .valid(valid), .cnt_in(cnt_in),
      .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
      .ff_valid(ff_valid), .ff_chan(ff_chan), .ff_exp(ff_exp), .ff_got(ff_got)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int a, input int r);
      checks++;
      if (a != r) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0d required=%0d", nm, nv, a, r);
      end
   endtask
   task automatic step(input logic r, input logic cl, input logic [3:0] v,
                       input int c0, input int c1, input int c2, input int c3,
                       input logic [3:0] p, input logic [3:0] s, input int n,
                       input logic fv, input int ch, input int fe, input int fg);
      exp_t e;
      @(negedge clk);
      rst = r;
      clear = cl;
      valid = v;
      cnt_in = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
      e.p = p;
      e.s = s;
      e.n = 2'(n);
      e.fv = fv;
      e.ch = 2'(ch);
      e.fe = 4'(fe);
      e.fg = 4'(fg);
      q.push_back(e);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("err_pulse", int'(err_pulse), int'(e.p));
            chk("err_sticky", int'(err_sticky), int'(e.s));
            chk("err_count", int'(err_count), int'(e.n));
            chk("ff_valid", int'(ff_valid), int'(e.fv));
            chk("ff_chan", int'(ff_chan), int'(e.ch));
            chk("ff_exp", int'(ff_exp), int'(e.fe));
            chk("ff_got", int'(ff_got), int'(e.fg));
            nv++;
         end
      end
   end
   initial begin
      rst = 1'b1;
      clear = 1'b0;
      valid = '0;
      cnt_in = '0;
      step(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(1, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++)
         step(0, 0, 4'b0001, k, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 3, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 4, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 6, 0, 0, 4'b0010, 4'b0010, 1, 1, 1, 5, 6);
      step(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0010, 1, 1, 1, 5, 6);
      step(0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 14, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 15, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 5, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0100, 0, 0, 9, 0, 4'b0100, 4'b0100, 1, 1, 2, 1, 9);
      step(0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b1001, 2, 0, 0, 7, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b1001, 4, 0, 0, 9, 4'b1001, 4'b1001, 2, 1, 0, 3, 4);
      step(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1001, 2, 1, 0, 3, 4);
      step(0, 0, 4'b1000, 0, 0, 0, 3, 4'b0000, 4'b1001, 2, 1, 0, 3, 4);
      step(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1001, 2, 1, 0, 3, 4);
      step(0, 0, 4'b1000, 0, 0, 0, 7, 4'b0000, 4'b1001, 2, 1, 0, 3, 4);
      step(0, 0, 4'b1000, 0, 0, 0, 9, 4'b1000, 4'b1001, 3, 1, 0, 3, 4);
      step(0, 0, 4'b1000, 0, 0, 0, 11, 4'b1000, 4'b1001, 3, 1, 0, 3, 4);
      step(0, 0, 4'b1000, 0, 0, 0, 13, 4'b1000, 4'b1001, 3, 1, 0, 3, 4);
      step(0, 1, 4'b1000, 0, 0, 0, 15, 4'b1000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 4, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 5, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 7, 0, 0, 4'b0010, 4'b0010, 1, 1, 1, 6, 7);
      step(1, 0, 4'b0010, 0, 8, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 9, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0010, 0, 10, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      step(0, 0, 4'b0001, 3, 0, 0, 0, 4'b0001, 4'b0001, 1, 1, 0, 2, 3);
      step(0, 0, 4'b0001, 5, 0, 0, 0, 4'b0001, 4'b0001, 2, 1, 0, 2, 3);
      step(0, 0, 4'b0001, 7, 0, 0, 0, 4'b0001, 4'b0001, 3, 1, 0, 2, 3);
      step(0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0001, 3, 1, 0, 2, 3);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
